proc_feeder: RTL and testbench
==============================

Name: proc_feeder

Overview:
- Program sequencer that sits directly upstream of the 9-bit bus processor.
- Holds a small loadable program memory and drives the processor's DIN and Run inputs, one instruction at a time.
- Paces itself on the processor's Done output, supplying the extra immediate word that an mvi instruction needs.
- Replaces the manual SW/KEY stimulus, so programs run back to back without an operator.

Parameters:
- AW, 5, program memory address width.
- DEPTH, 32, number of program words (2**AW).
- MVI_OP, 3'b001, opcode value in DIN[8:6] that marks an instruction followed by an immediate word.
- WDOG, 8, maximum cycles from Run to Done before the feeder flags an error.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Resetn  in  1  synchronous, active-low reset.
- Start  in  1  begin execution at address 0; honoured only in IDLE.
- Stop  in  1  abort at the next instruction boundary.
- ProgLen  in  AW+1  number of words in the program; sampled into LenReg on an accepted Start.
- WrEn  in  1  program memory write strobe; honoured only in IDLE.
- WrAddr  in  AW  program memory write address.
- WrData  in  9  program memory write data.
- Done  in  1  processor Done (combinational, asserted in the last cycle of an instruction).
- DIN  out  9  instruction or immediate word to the processor.
- Run  out  1  processor Run.
- Busy  out  1  high in every state except IDLE.
- Finished  out  1  one-cycle pulse when the program ends normally or by Stop.
- Error  out  1  sticky watchdog-timeout flag; cleared by reset or by the next accepted Start.
- PC  out  AW+1  current program counter.

Behaviour:
- Reset (Resetn=0 at a clock edge, overrides everything):
  - state=IDLE; PC=0; LenReg=0; InstrReg=0; ImmReg=0; watchdog count=0.
  - DIN=0, Run=0, Busy=0, Finished=0, Error=0.
  - Memory contents are not reset.
  - Reset mid-program returns to IDLE immediately. The processor must be reset together with the feeder.
- Memory: DEPTH x 9 register array, combinational read at index PC[AW-1:0] (wraps modulo DEPTH). Write takes effect at the clock edge.
- States:
  - IDLE:
    - Run=0, DIN=0.
    - WrEn=1 writes mem[WrAddr]=WrData.
    - Start=1 and ProgLen!=0: LenReg<=ProgLen, PC<=0, Error<=0, go FETCH.
    - Start=1 and ProgLen=0: Finished pulses next cycle and the state stays IDLE.
    - Start and WrEn together: the write happens, then Start is processed.
  - FETCH (1 cycle): InstrReg<=mem[PC], PC<=PC+1, go ISSUE.
  - ISSUE (exactly 1 cycle; the processor is in T0 and captures IR):
    - DIN=InstrReg, Run=1.
    - If InstrReg[8:6]==MVI_OP: ImmReg<=mem[PC], PC<=PC+1.
    - Clear the watchdog, go WAIT.
  - WAIT:
    - Run=0.
    - DIN=ImmReg if the current instruction is mvi, else 0. The immediate is therefore valid in the processor's T1 cycle.
    - The watchdog increments each cycle.
    - On Done=1:
      - if a Stop is latched or PC>=LenReg: go IDLE, pulse Finished;
      - otherwise go FETCH.
    - If the watchdog reaches WDOG without Done: Error<=1, go IDLE, no Finished pulse.
- Instruction spacing: ISSUE, then WAIT until Done, then FETCH, then the next ISSUE. The processor idles one cycle in T0 with Run=0 between instructions.
- Stop:
  - A Stop pulse in any non-IDLE state is latched and never cancels an instruction in flight.
  - Stop in the same cycle as Done ends the program at that Done.
  - Stop in IDLE is ignored.
- Trailing mvi: an mvi as the last word (PC==LenReg after fetch) still reads the immediate from mem[PC mod DEPTH]. The program ends after its Done.
- WrEn while Busy is ignored; memory is unchanged.
- Start while Busy is ignored.
- Busy is asserted from the cycle after an accepted Start until the cycle the state returns to IDLE.

Test Plan:
- Load mem[0]=9'b001000000 (mvi R0), mem[1]=9'd5, mem[2]=9'b000001000 (mv R1,R0), ProgLen=3, Start, with the processor connected:
  - Run pulses exactly twice.
  - DIN=5 in the cycle after the first Run.
  - Finished pulses once; final PC=3; R0=R1=5.
- Program mvi R0,#3; mvi R1,#2; add R0,R1 (ProgLen=5) -> G drives 5 on the bus in the add's T3; Done is seen 3 times; Busy stays high from Start until Finished.
- Stub Done tied 0, program of 1 word -> Error=1 exactly WDOG cycles after the Run pulse; Finished stays 0; state returns to IDLE; the next Start clears Error.
- 4-instruction program, Stop pulsed during the second instruction's WAIT -> the second instruction completes, the third is never issued, Finished pulses, PC=2.
- Resetn=0 asserted in the middle of an add -> next cycle Run=0, DIN=0, Busy=0, PC=0. WrEn while Busy (mem[0]<=9'h1FF) -> after the run completes, mem[0] reads back its old value.
- Start with ProgLen=0 -> Finished pulses once, Run never asserts. Start with ProgLen=32 and a wrap-around trailing mvi -> the immediate is taken from mem[0].

Source files
------------

// File: rtl/proc_feeder.sv
// proc_feeder
// Program sequencer for the 9-bit bus processor. Holds a loadable program
// memory and feeds the processor one instruction at a time on DIN/Run,
// pacing itself on the processor's Done and supplying the immediate word
// that follows an mvi. A watchdog flags instructions that never finish.
//
// Ports
//   Clock, Resetn     rising-edge clock, synchronous active-low reset
//   Start, Stop       begin program at address 0 / end at next boundary
//   ProgLen           program length in words (sampled on accepted Start)
//   WrEn/WrAddr/WrData program memory write port (IDLE only)
//   Done              processor Done, combinational, last cycle of an instr
//   DIN, Run          processor bus word and Run strobe
//   Busy, Finished    not-IDLE flag / one-cycle end-of-program pulse
//   Error             sticky watchdog timeout
//   PC                program counter (one bit wider than the memory index)
module proc_feeder #(
   parameter int         AW     = 5,
   parameter int         DEPTH  = 32,
   parameter logic [2:0] MVI_OP = 3'b001,
   parameter int         WDOG   = 8
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          Start,
   input  logic          Stop,
   input  logic [AW:0]   ProgLen,
   input  logic          WrEn,
   input  logic [AW-1:0] WrAddr,
   input  logic [8:0]    WrData,
   input  logic          Done,
   output logic [8:0]    DIN,
   output logic          Run,
   output logic          Busy,
   output logic          Finished,
   output logic          Error,
   output logic [AW:0]   PC
);

   localparam int          WDW    = $clog2(WDOG + 1);
   localparam logic [AW:0] PC_ONE = 1;

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT} state_t;

   state_t         state;
   logic [8:0]     mem [DEPTH];
   logic [AW:0]    len_reg;
   logic [8:0]     instr_reg;
   logic [8:0]     imm_reg;
   logic [WDW-1:0] wd_cnt;
   logic           stop_lat;
   logic [8:0]     rd_word;
   logic           is_mvi;

   // PC is one bit wider than the index, so reads wrap modulo DEPTH; this is
   // what lets a trailing mvi take its immediate from address 0.
   assign rd_word = mem[PC[AW-1:0]];
   assign is_mvi  = (instr_reg[8:6] == MVI_OP);

   // Memory is deliberately not reset; only IDLE accepts writes.
   always_ff @(posedge Clock) begin
      if (Resetn && WrEn && state == IDLE)
         mem[WrAddr] <= WrData;
   end

   // DIN is a pure decode of registered state: the instruction during ISSUE
   // (processor T0) and the immediate during WAIT (processor T1 onward).
   always_comb begin
      DIN = '0;
      case (state)
         ISSUE:   DIN = instr_reg;
         WAIT:    if (is_mvi) DIN = imm_reg;
         default: DIN = '0;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state     <= IDLE;
         PC        <= '0;
         len_reg   <= '0;
         instr_reg <= '0;
         imm_reg   <= '0;
         wd_cnt    <= '0;
         stop_lat  <= 1'b0;
         Run       <= 1'b0;
         Busy      <= 1'b0;
         Finished  <= 1'b0;
         Error     <= 1'b0;
      end else begin
         Finished <= 1'b0;
         // Stop only takes effect at the next Done; it never aborts an
         // instruction the processor has already captured.
         if (Stop && state != IDLE) stop_lat <= 1'b1;

         case (state)
            IDLE: begin
               Run <= 1'b0;
               if (Start) begin
                  if (ProgLen != '0) begin
                     len_reg <= ProgLen;
                     PC      <= '0;
                     Error   <= 1'b0;
                     Busy    <= 1'b1;
                     state   <= FETCH;
                  end else begin
                     Finished <= 1'b1;
                  end
               end
            end

            FETCH: begin
               instr_reg <= rd_word;
               PC        <= PC + PC_ONE;
               Run       <= 1'b1;
               state     <= ISSUE;
            end

            ISSUE: begin
               Run    <= 1'b0;
               wd_cnt <= '0;
               state  <= WAIT;
               if (is_mvi) begin
                  imm_reg <= rd_word;
                  PC      <= PC + PC_ONE;
               end
            end

            WAIT: begin
               if (Done) begin
                  if (stop_lat || Stop || PC >= len_reg) begin
                     state    <= IDLE;
                     Busy     <= 1'b0;
                     Finished <= 1'b1;
                     stop_lat <= 1'b0;
                  end else begin
                     state <= FETCH;
                  end
               end else if (wd_cnt == WDW'(WDOG - 1)) begin
                  // WDOG full WAIT cycles without Done: give up silently.
                  Error    <= 1'b1;
                  state    <= IDLE;
                  Busy     <= 1'b0;
                  stop_lat <= 1'b0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_proc_feeder.sv
// Bench for proc_feeder: a small cycle model of the 9-bit bus processor
// (mv/mvi/add/sub) is attached, and program outcomes (Run count, cycle
// count, final PC, register file) are compared to an instruction-level
// reference that walks the program memory shadow.
module tb_proc_feeder;
   localparam int AW = 5, DEPTH = 32, WDOG = 8;

   logic          Clock = 1'b0, Resetn = 1'b0, Start = 1'b0, Stop = 1'b0, WrEn = 1'b0;
   logic [AW:0]   ProgLen = '0;
   logic [AW-1:0] WrAddr = '0;
   logic [8:0]    WrData = '0;
   logic          Done;
   logic [8:0]    DIN;
   logic          Run, Busy, Finished, Error;
   logic [AW:0]   PC;

   int n_tests = 0, n_fail = 0;

   always #5 Clock = ~Clock;

   proc_feeder #(.AW(AW), .DEPTH(DEPTH), .MVI_OP(3'b001), .WDOG(WDOG)) dut (
      .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop), .ProgLen(ProgLen),
      .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Done(Done), .DIN(DIN),
      .Run(Run), .Busy(Busy), .Finished(Finished), .Error(Error), .PC(PC));

   // ---------------- processor model ----------------
   logic [8:0] R [8];
   logic [8:0] A = '0, G = '0, IR = '0;
   int         p_step = 0;
   logic       stub = 1'b0;
   logic       proc_done;

   always_comb begin
      proc_done = 1'b0;
      if (p_step == 1 && IR[8:7] == 2'b00) proc_done = 1'b1;
      if (p_step == 3) proc_done = 1'b1;
   end
   assign Done = stub ? 1'b0 : proc_done;

   always @(posedge Clock) begin
      if (!Resetn) begin
         p_step <= 0; IR <= '0; A <= '0; G <= '0;
         for (int i = 0; i < 8; i++) R[i] <= '0;
      end else begin
         case (p_step)
            0: if (Run) begin IR <= DIN; p_step <= 1; end
            1: begin
               case (IR[8:6])
                  3'b000:  R[IR[5:3]] <= R[IR[2:0]];
                  3'b001:  R[IR[5:3]] <= DIN;
                  default: A <= R[IR[5:3]];
               endcase
               p_step <= (IR[8:7] == 2'b00) ? 0 : 2;
            end
            2: begin
               G <= (IR[8:6] == 3'b010) ? A + R[IR[2:0]] : A - R[IR[2:0]];
               p_step <= 3;
            end
            default: begin R[IR[5:3]] <= G; p_step <= 0; end
         endcase
      end
   end

   // ---------------- reference model ----------------
   logic [8:0] shadow [DEPTH];
   logic [8:0] e_R [8];
   int e_runs, e_cyc, e_pc;

   task automatic ref_run(input int len, input int stop_on);
      int pc, op, x, y;
      logic [8:0] ins;
      for (int i = 0; i < 8; i++) e_R[i] = '0;
      e_runs = 0; e_cyc = 0; pc = 0;
      while (pc < len && !(stop_on > 0 && e_runs == stop_on)) begin
         ins = shadow[pc % DEPTH]; pc++; e_runs++;
         op = int'(ins[8:6]); x = int'(ins[5:3]); y = int'(ins[2:0]);
         case (op)
            0: begin e_R[x] = e_R[y]; e_cyc += 3; end
            1: begin e_R[x] = shadow[pc % DEPTH]; pc++; e_cyc += 3; end
            2: begin e_R[x] = e_R[x] + e_R[y]; e_cyc += 5; end
            default: begin e_R[x] = e_R[x] - e_R[y]; e_cyc += 5; end
         endcase
      end
      e_pc = pc;
   endtask

   // ---------------- stimulus helpers ----------------
   int r_runs, r_fins, r_dones, r_end, r_last_run;
   bit r_ended;
   logic [8:0] r_g3;
   logic [8:0] q_din_run[$], q_din_after[$];

   task automatic cyc1(); @(posedge Clock); #1; endtask

   task automatic do_reset();
      Resetn = 1'b0; Start = 1'b0; Stop = 1'b0; WrEn = 1'b0;
      cyc1(); cyc1();
      Resetn = 1'b1;
   endtask

   task automatic wr(input int a, input logic [8:0] d);
      WrEn = 1'b1; WrAddr = a[AW-1:0]; WrData = d; shadow[a] = d;
      cyc1();
      WrEn = 1'b0;
   endtask

   task automatic run_watch(input int len, input int stop_on, input bit wr_busy, input int budget);
      bit prev_run;
      r_runs = 0; r_fins = 0; r_dones = 0; r_ended = 0; r_end = -1; r_last_run = -1;
      r_g3 = '0; q_din_run.delete(); q_din_after.delete(); prev_run = 0;
      ProgLen = len[AW:0]; Start = 1'b1; cyc1(); Start = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (prev_run) q_din_after.push_back(DIN);
         if (Run) begin r_runs++; r_last_run = c; q_din_run.push_back(DIN); end
         if (Done) r_dones++;
         if (Finished) r_fins++;
         if (p_step == 3) r_g3 = G;
         if (!Busy) begin r_ended = 1; r_end = c; break; end
         Stop   = (stop_on > 0 && prev_run && r_runs == stop_on);
         WrEn   = wr_busy && c == 0;
         WrAddr = '0; WrData = 9'h1FF;
         prev_run = Run;
         cyc1();
      end
      Stop = 1'b0; WrEn = 1'b0;
      n_tests++;
      if (!r_ended) begin n_fail++; $display("FAIL run_timeout: busy after %0d cycles, required idle", budget); end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_tests++; if (Run !== 1'b0)      begin n_fail++; $display("FAIL reset_run: got %b want 0", Run); end
      n_tests++; if (DIN !== 9'd0)      begin n_fail++; $display("FAIL reset_din: got %h want 0", DIN); end
      n_tests++; if (Busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
      n_tests++; if (Finished !== 1'b0) begin n_fail++; $display("FAIL reset_fin: got %b want 0", Finished); end
      n_tests++; if (Error !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b want 0", Error); end
      n_tests++; if (PC !== '0)         begin n_fail++; $display("FAIL reset_pc: got %0d want 0", PC); end
      for (int i = 0; i < DEPTH; i++) wr(i, 9'd0);
   endtask

   task automatic test_mvi_mv();
      do_reset();
      wr(0, 9'h040); wr(1, 9'd5); wr(2, 9'h008);
      ref_run(3, 0);
      run_watch(3, 0, 0, 200);
      n_tests++; if (r_runs != 2) begin n_fail++; $display("FAIL mvi_runs: got %0d want 2", r_runs); end
      n_tests++; if (q_din_after.size() < 1 || q_din_after[0] !== 9'd5)
         begin n_fail++; $display("FAIL mvi_imm: got %h want 005", q_din_after.size() > 0 ? q_din_after[0] : 9'h0); end
      n_tests++; if (r_fins != 1) begin n_fail++; $display("FAIL mvi_fin: got %0d want 1", r_fins); end
      n_tests++; if (PC !== 6'd3) begin n_fail++; $display("FAIL mvi_pc: got %0d want 3", PC); end
      n_tests++; if (R[0] !== 9'd5 || R[1] !== 9'd5) begin n_fail++; $display("FAIL mvi_regs: got %0d,%0d want 5,5", R[0], R[1]); end
      n_tests++; if (r_end != e_cyc) begin n_fail++; $display("FAIL mvi_cycles: got %0d want %0d", r_end, e_cyc); end
   endtask

   task automatic test_add();
      do_reset();
      wr(0, 9'h040); wr(1, 9'd3); wr(2, 9'h048); wr(3, 9'd2); wr(4, 9'h081);
      ref_run(5, 0);
      run_watch(5, 0, 0, 200);
      n_tests++; if (r_g3 !== 9'd5) begin n_fail++; $display("FAIL add_bus: got %0d want 5", r_g3); end
      n_tests++; if (r_dones != 3)  begin n_fail++; $display("FAIL add_dones: got %0d want 3", r_dones); end
      n_tests++; if (r_fins != 1)   begin n_fail++; $display("FAIL add_fin: got %0d want 1", r_fins); end
      n_tests++; if (r_end != e_cyc) begin n_fail++; $display("FAIL add_busy_span: got %0d want %0d", r_end, e_cyc); end
      n_tests++; if (R[0] !== e_R[0]) begin n_fail++; $display("FAIL add_r0: got %0d want %0d", R[0], e_R[0]); end
   endtask

   task automatic test_watchdog();
      do_reset();
      wr(0, 9'h008);
      stub = 1'b1;
      run_watch(1, 0, 0, 100);
      stub = 1'b0;
      n_tests++; if (Error !== 1'b1) begin n_fail++; $display("FAIL wd_error: got %b want 1", Error); end
      n_tests++; if (r_fins != 0)    begin n_fail++; $display("FAIL wd_fin: got %0d want 0", r_fins); end
      n_tests++; if (r_end - r_last_run != WDOG + 1)
         begin n_fail++; $display("FAIL wd_timing: got %0d want %0d", r_end - r_last_run, WDOG + 1); end
      run_watch(1, 0, 0, 100);
      n_tests++; if (Error !== 1'b0) begin n_fail++; $display("FAIL wd_clear: got %b want 0", Error); end
      n_tests++; if (r_fins != 1)    begin n_fail++; $display("FAIL wd_rerun_fin: got %0d want 1", r_fins); end
   endtask

   task automatic test_stop();
      do_reset();
      wr(0, 9'h008); wr(1, 9'h081); wr(2, 9'h008); wr(3, 9'h008);
      ref_run(4, 2);
      run_watch(4, 2, 0, 200);
      n_tests++; if (r_runs != 2)   begin n_fail++; $display("FAIL stop_runs: got %0d want 2", r_runs); end
      n_tests++; if (r_dones != 2)  begin n_fail++; $display("FAIL stop_dones: got %0d want 2", r_dones); end
      n_tests++; if (r_fins != 1)   begin n_fail++; $display("FAIL stop_fin: got %0d want 1", r_fins); end
      n_tests++; if (PC !== 6'd2)   begin n_fail++; $display("FAIL stop_pc: got %0d want 2", PC); end
      n_tests++; if (r_end != e_cyc) begin n_fail++; $display("FAIL stop_cycles: got %0d want %0d", r_end, e_cyc); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      do_reset();
      wr(0, 9'h081); wr(1, 9'h081);
      ProgLen = 6'd2; Start = 1'b1; cyc1(); Start = 1'b0;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         if (Run) seen = 1;
         cyc1();
      end
      n_tests++; if (!seen) begin n_fail++; $display("FAIL midrst_norun: no Run in 10 cycles, required one"); end
      Resetn = 1'b0; cyc1();
      n_tests++; if (Run !== 1'b0 || DIN !== 9'd0 || Busy !== 1'b0 || PC !== '0)
         begin n_fail++; $display("FAIL midrst_state: run=%b din=%h busy=%b pc=%0d want all 0", Run, DIN, Busy, PC); end
      Resetn = 1'b1; cyc1();
      // write attempted while busy must not reach memory
      run_watch(1, 0, 1, 100);
      run_watch(1, 0, 0, 100);
      n_tests++; if (q_din_run.size() < 1 || q_din_run[0] !== shadow[0])
         begin n_fail++; $display("FAIL busy_write: got %h want %h", q_din_run.size() > 0 ? q_din_run[0] : 9'h0, shadow[0]); end
   endtask

   task automatic test_zero_len();
      do_reset();
      run_watch(0, 0, 0, 20);
      n_tests++; if (r_fins != 1 || r_end != 0) begin n_fail++; $display("FAIL zlen_fin: got fins=%0d end=%0d want 1,0", r_fins, r_end); end
      n_tests++; if (r_runs != 0) begin n_fail++; $display("FAIL zlen_run: got %0d want 0", r_runs); end
      cyc1();
      n_tests++; if (Finished !== 1'b0 || Run !== 1'b0) begin n_fail++; $display("FAIL zlen_pulse: fin=%b run=%b want 0,0", Finished, Run); end
   endtask

   task automatic test_wrap();
      do_reset();
      wr(0, 9'h01B);
      for (int i = 1; i < 31; i++) wr(i, {3'b000, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))});
      wr(31, 9'h050);
      ref_run(32, 0);
      run_watch(32, 0, 0, 400);
      n_tests++; if (r_runs != e_runs) begin n_fail++; $display("FAIL wrap_runs: got %0d want %0d", r_runs, e_runs); end
      n_tests++; if (R[2] !== e_R[2])  begin n_fail++; $display("FAIL wrap_imm: got %h want %h", R[2], e_R[2]); end
      n_tests++; if (PC !== 6'(e_pc))  begin n_fail++; $display("FAIL wrap_pc: got %0d want %0d", PC, e_pc); end
      n_tests++; if (r_end != e_cyc)   begin n_fail++; $display("FAIL wrap_cycles: got %0d want %0d", r_end, e_cyc); end
   endtask

   task automatic test_random();
      int len, stop_on;
      for (int it = 0; it < 15; it++) begin
         do_reset();
         for (int i = 0; i < DEPTH; i++)
            wr(i, {1'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))});
         len     = $urandom_range(1, 12);
         stop_on = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
         ref_run(len, stop_on);
         run_watch(len, stop_on, 0, 400);
         n_tests++; if (r_runs != e_runs) begin n_fail++; $display("FAIL rnd%0d_runs: got %0d want %0d", it, r_runs, e_runs); end
         n_tests++; if (r_dones != e_runs) begin n_fail++; $display("FAIL rnd%0d_dones: got %0d want %0d", it, r_dones, e_runs); end
         n_tests++; if (r_fins != 1) begin n_fail++; $display("FAIL rnd%0d_fin: got %0d want 1", it, r_fins); end
         n_tests++; if (PC !== 6'(e_pc)) begin n_fail++; $display("FAIL rnd%0d_pc: got %0d want %0d", it, PC, e_pc); end
         n_tests++; if (r_end != e_cyc) begin n_fail++; $display("FAIL rnd%0d_cycles: got %0d want %0d", it, r_end, e_cyc); end
         for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (R[k] !== e_R[k]) begin n_fail++; $display("FAIL rnd%0d_r%0d: got %h want %h", it, k, R[k], e_R[k]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_mvi_mv();
      test_add();
      test_watchdog();
      test_stop();
      test_reset_mid();
      test_zero_len();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1);
   end

endmodule
